// File: rtl/cpu_pkg.sv
// Shared fetch-stage types and constants.
package cpu_pkg;

  typedef enum logic {
    StIdle = 1'b0,
    StRun  = 1'b1
  } fetch_state_e;

  localparam int unsigned DefaultStep = 4;

endpackage

// File: rtl/tick_gen.sv
// Free-running divider: tick is high in every cycle where the count equals DIV-1.
module tick_gen #(
  parameter int unsigned DIV = 1
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);

  localparam int unsigned CntW   = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(DIV - 1);

  logic [CntW-1:0] count_q, count_d;
  logic            tick_q;

  // Wrap the count at DIV-1.
  always_comb begin
    count_d = (count_q == CntMax) ? '0 : count_q + CntW'(1);
  end

  // tick is registered against the value the count is about to take, so it tracks count_q.
  always_ff @(posedge clk) begin
    if (!rst) begin
      count_q <= '0;
      tick_q  <= 1'b0;
    end else begin
      count_q <= count_d;
      tick_q  <= (count_d == CntMax);
    end
  end

  assign tick = tick_q;

endmodule

// File: rtl/pc_fetch.sv
// Fetch stage: PC sequencing with jump/branch redirects, a one-entry pending redirect
// and a one-cycle synchronous-read fetch tag.
module pc_fetch
  import cpu_pkg::*;
#(
  parameter int unsigned       ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter int unsigned       STEP     = DefaultStep,
  parameter int unsigned       DIV      = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic              branch,
  input  logic [ADDR_W-1:0] branch_target,
  input  logic              jump,
  input  logic [ADDR_W-1:0] jump_target,
  output logic [ADDR_W-1:0] pc,
  output logic              inst_en,
  output logic              tick,
  output logic              fetch_valid,
  output logic [ADDR_W-1:0] fetch_pc
);

  fetch_state_e      state_q;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic              pend_valid_q, pend_valid_d;
  logic [ADDR_W-1:0] pend_tgt_q, pend_tgt_d;
  logic              fetch_valid_q;
  logic [ADDR_W-1:0] fetch_pc_q;
  logic              redirect;

  tick_gen #(
    .DIV (DIV)
  ) u_tick_gen (
    .clk  (clk),
    .rst  (rst),
    .tick (tick)
  );

  // Read enable has to honour stall in the same cycle, so it is decoded from state_q.
  assign inst_en  = (state_q == StRun) && tick && !stall;
  assign redirect = jump || branch || pend_valid_q;

  // Next PC and pending-redirect bookkeeping.
  always_comb begin
    pc_d         = pc_q;
    pend_valid_d = pend_valid_q;
    pend_tgt_d   = pend_tgt_q;
    if (inst_en) begin
      if (jump)              pc_d = jump_target;
      else if (branch)       pc_d = branch_target;
      else if (pend_valid_q) pc_d = pend_tgt_q;
      else                   pc_d = pc_q + ADDR_W'(STEP);
      // Consumed, or superseded by a live request.
      pend_valid_d = 1'b0;
    end else if (jump || branch) begin
      pend_valid_d = 1'b1;
      pend_tgt_d   = jump ? jump_target : branch_target;
    end
  end

  // FSM, PC, pending entry and fetch tag.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q       <= StIdle;
      pc_q          <= RESET_PC;
      pend_valid_q  <= 1'b0;
      pend_tgt_q    <= '0;
      fetch_valid_q <= 1'b0;
      fetch_pc_q    <= RESET_PC;
    end else begin
      case (state_q)
        StIdle:  state_q <= StRun;
        default: state_q <= StRun;
      endcase
      pc_q         <= pc_d;
      pend_valid_q <= pend_valid_d;
      pend_tgt_q   <= pend_tgt_d;
      // Squash the fall-through word fetched alongside a redirect.
      fetch_valid_q <= inst_en && !redirect;
      if (inst_en) fetch_pc_q <= pc_q;
    end
  end

  assign pc          = pc_q;
  assign fetch_valid = fetch_valid_q;
  assign fetch_pc    = fetch_pc_q;

endmodule

// File: tb/tb_pc_fetch.sv
// Directed bench for pc_fetch: DIV=1 main instance, DIV=4 instance, 8-bit wrap instance.
module tb_pc_fetch;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall, branch, jump;
  logic [31:0] branch_target, jump_target;

  logic [31:0] pc_a, fpc_a;
  logic        en_a, tick_a, fv_a;
  logic [31:0] pc_b, fpc_b;
  logic        en_b, tick_b, fv_b;
  logic [7:0]  pc_c, fpc_c;
  logic        en_c, tick_c, fv_c;

  int          checks   = 0;
  int          failures = 0;
  logic [31:0] sb[$];

  always #5 clk = ~clk;

  pc_fetch #(.DIV(1)) u_dut_a (
    .clk           (clk),
    .rst           (rst),
    .stall         (stall),
    .branch        (branch),
    .branch_target (branch_target),
    .jump          (jump),
    .jump_target   (jump_target),
    .pc            (pc_a),
    .inst_en       (en_a),
    .tick          (tick_a),
    .fetch_valid   (fv_a),
    .fetch_pc      (fpc_a)
  );

  pc_fetch #(.DIV(4)) u_dut_b (
    .clk           (clk),
    .rst           (rst),
    .stall         (1'b0),
    .branch        (1'b0),
    .branch_target (32'h0),
    .jump          (1'b0),
    .jump_target   (32'h0),
    .pc            (pc_b),
    .inst_en       (en_b),
    .tick          (tick_b),
    .fetch_valid   (fv_b),
    .fetch_pc      (fpc_b)
  );

  pc_fetch #(.ADDR_W(8), .RESET_PC(8'hFC), .STEP(4), .DIV(1)) u_dut_c (
    .clk           (clk),
    .rst           (rst),
    .stall         (1'b0),
    .branch        (1'b0),
    .branch_target (8'h0),
    .jump          (1'b0),
    .jump_target   (8'h0),
    .pc            (pc_c),
    .inst_en       (en_c),
    .tick          (tick_c),
    .fetch_valid   (fv_c),
    .fetch_pc      (fpc_c)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock and retire any fetch the main instance presents.
  task automatic cyc();
    logic [31:0] exp;
    @(posedge clk);
    #1;
    if (fv_a === 1'b1) begin
      checks++;
      assert (sb.size() != 0) else begin
        failures++;
        $error("FAIL sb_underflow observed=fetch_pc_0x%0h expected=no_fetch", fpc_a);
      end
      if (sb.size() != 0) begin
        exp = sb.pop_front();
        chk("sb_fetch_pc", fpc_a, exp);
      end
    end
  endtask

  initial begin
    rst = 1'b0; stall = 1'b0; branch = 1'b0; jump = 1'b0;
    branch_target = '0; jump_target = '0;
    cyc(); cyc();
    chk("rst_pc", pc_a, 32'h0);
    chk("rst_inst_en", 32'(en_a), 32'h0);
    chk("rst_fetch_valid", 32'(fv_a), 32'h0);
    chk("rst_fetch_pc", fpc_a, 32'h0);
    chk("rst_tick", 32'(tick_a), 32'h0);
    chk("rst_pc_c", 32'(pc_c), 32'hFC);
    chk("rst_fetch_pc_c", 32'(fpc_c), 32'hFC);
    chk("rst_tick_b", 32'(tick_b), 32'h0);

    rst = 1'b1;
    cyc(); // c1
    chk("c1_inst_en", 32'(en_a), 32'h1);
    chk("c1_pc", pc_a, 32'h0);
    chk("c1_tick", 32'(tick_a), 32'h1);
    chk("c1_fetch_valid", 32'(fv_a), 32'h0);
    chk("c1_pc_c", 32'(pc_c), 32'hFC);
    chk("c1_inst_en_b", 32'(en_b), 32'h0);
    sb.push_back(32'h0);
    cyc(); // c2
    chk("c2_pc", pc_a, 32'h4);
    chk("c2_fetch_valid", 32'(fv_a), 32'h1);
    chk("c2_pc_c_wrap", 32'(pc_c), 32'h00);
    chk("c2_fetch_pc_c", 32'(fpc_c), 32'hFC);
    chk("c2_tick_b", 32'(tick_b), 32'h0);
    sb.push_back(32'h4);
    cyc(); // c3
    chk("c3_pc", pc_a, 32'h8);
    chk("c3_pc_c", 32'(pc_c), 32'h04);
    chk("c3_tick_b", 32'(tick_b), 32'h1);
    chk("c3_inst_en_b", 32'(en_b), 32'h1);
    chk("c3_pc_b", pc_b, 32'h0);
    sb.push_back(32'h8);
    cyc(); // c4
    chk("c4_pc", pc_a, 32'hC);
    chk("c4_pc_b", pc_b, 32'h4);
    chk("c4_inst_en_b", 32'(en_b), 32'h0);

    // Same-cycle jump and branch with inst_en high: jump wins, nothing left pending.
    jump = 1'b1; jump_target = 32'h200; branch = 1'b1; branch_target = 32'h300;
    #1;
    chk("tie_inst_en", 32'(en_a), 32'h1);
    cyc(); // c5
    chk("tie_pc", pc_a, 32'h200);
    chk("tie_squash", 32'(fv_a), 32'h0);
    jump = 1'b0; branch = 1'b0;
    sb.push_back(32'h200);
    cyc(); // c6
    chk("tie_no_pending", pc_a, 32'h204);

    // Branch under stall is held pending and applied once stall drops.
    stall = 1'b1; branch = 1'b1; branch_target = 32'h100;
    #1;
    chk("stall_inst_en", 32'(en_a), 32'h0);
    cyc(); // c7
    chk("stall_pc_hold", pc_a, 32'h204);
    chk("stall_fetch_valid", 32'(fv_a), 32'h0);
    chk("c7_inst_en_b", 32'(en_b), 32'h1);
    chk("c7_pc_b", pc_b, 32'h4);
    branch = 1'b0;
    cyc(); // c8
    chk("c8_pc_b", pc_b, 32'h8);
    cyc(); // c9
    stall = 1'b0;
    #1;
    chk("unstall_inst_en", 32'(en_a), 32'h1);
    cyc(); // c10
    chk("pend_pc", pc_a, 32'h100);
    chk("pend_squash", 32'(fv_a), 32'h0);
    sb.push_back(32'h100);
    cyc(); // c11
    chk("pend_next_pc", pc_a, 32'h104);
    chk("pend_fetch_valid", 32'(fv_a), 32'h1);

    // Pending: jump wins a tie, then a later branch overwrites it.
    stall = 1'b1; branch = 1'b1; branch_target = 32'h300; jump = 1'b1; jump_target = 32'h400;
    cyc(); // c12
    jump = 1'b0; branch_target = 32'h500;
    cyc(); // c13
    branch = 1'b0; stall = 1'b0;
    cyc(); // c14
    chk("overwrite_pc", pc_a, 32'h500);

    // A live request beats the pending entry and clears it.
    stall = 1'b1; branch = 1'b1; branch_target = 32'h600;
    cyc(); // c15
    stall = 1'b0; branch = 1'b0; jump = 1'b1; jump_target = 32'h700;
    cyc(); // c16
    chk("live_over_pend_pc", pc_a, 32'h700);
    chk("live_over_pend_squash", 32'(fv_a), 32'h0);
    jump = 1'b0;
    sb.push_back(32'h700);
    cyc(); // c17
    chk("pend_cleared_pc", pc_a, 32'h704);

    // Reset with a pending redirect discards it and the in-flight fetch.
    stall = 1'b1; branch = 1'b1; branch_target = 32'h800;
    cyc(); // c18
    branch = 1'b0; stall = 1'b0; rst = 1'b0;
    cyc(); // c19
    chk("mid_rst_pc", pc_a, 32'h0);
    chk("mid_rst_inst_en", 32'(en_a), 32'h0);
    chk("mid_rst_fetch_valid", 32'(fv_a), 32'h0);
    chk("mid_rst_fetch_pc", fpc_a, 32'h0);
    rst = 1'b1;
    cyc(); // c20
    chk("post_rst_inst_en", 32'(en_a), 32'h1);
    chk("post_rst_pc", pc_a, 32'h0);
    chk("post_rst_fetch_valid", 32'(fv_a), 32'h0);
    sb.push_back(32'h0);
    cyc(); // c21
    chk("post_rst_next_pc", pc_a, 32'h4);
    chk("sb_drained", sb.size(), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
